// File: rtl/demux_pkg.sv
// Shared definitions for the stream demux router: FSM state encoding and
// the helper that locates a channel's slice in a packed output bus.
package demux_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PKT  = 2'd1;
    localparam state_t ST_DROP = 2'd2;

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready holding register carrying a data word plus a last flag.
module stream_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    output logic             can_accept,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    logic push;

    // A full slot can still take a beat when the downstream pops it this cycle.
    assign can_accept = !out_valid || out_ready;
    assign push       = push_valid && can_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
            out_last  <= push_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_router.sv
// Routes a valid/ready stream to one of N_OUT buffered channels, locking the
// destination for the whole packet and dropping packets with an illegal select.
module demux_stream_router #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 8,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [SEL_W-1:0]       in_sel,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    output logic [N_OUT-1:0]       out_last,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   err_sel,
    output logic                   busy,
    output logic [SEL_W-1:0]       active_sel
);

    import demux_pkg::*;

    localparam int N_PAD = 1 << SEL_W;

    state_t             state;
    logic [SEL_W-1:0]   target_sel;
    logic               sel_legal;
    logic               route_en;
    logic               accept;
    logic [N_OUT-1:0]   can_accept;
    logic [N_PAD-1:0]   can_accept_ext;
    logic [N_OUT-1:0]   push_en;

    // Padding lets an out-of-range select index the ready vector safely.
    assign can_accept_ext = N_PAD'(can_accept);
    assign target_sel     = (state == ST_PKT) ? active_sel : in_sel;
    assign sel_legal      = ({{(32-SEL_W){1'b0}}, in_sel} < 32'(N_OUT));
    assign route_en       = (state == ST_PKT) || ((state == ST_IDLE) && sel_legal);
    assign accept         = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_IDLE: in_ready = sel_legal ? can_accept_ext[in_sel] : 1'b1;
            ST_PKT:  in_ready = can_accept_ext[active_sel];
            ST_DROP: in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    genvar i;
    generate
        for (i = 0; i < N_OUT; i++) begin : g_slot
            assign push_en[i] = in_valid && route_en && (target_sel == SEL_W'(i));

            stream_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .push_valid(push_en[i]),
                .push_data (in_data),
                .push_last (in_last),
                .can_accept(can_accept[i]),
                .out_valid (out_valid[i]),
                .out_data  (out_data[slice_lsb(i, WIDTH) +: WIDTH]),
                .out_last  (out_last[i]),
                .out_ready (out_ready[i])
            );
        end
    endgenerate

    // active_sel doubles as the lock register; err_sel is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            err_sel    <= 1'b0;
            busy       <= 1'b0;
            active_sel <= '0;
        end else begin
            err_sel <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!sel_legal) begin
                            err_sel <= 1'b1;
                            if (!in_last) state <= ST_DROP;
                        end else if (!in_last) begin
                            state      <= ST_PKT;
                            busy       <= 1'b1;
                            active_sel <= in_sel;
                        end
                    end
                end
                ST_PKT: begin
                    if (accept && in_last) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        active_sel <= '0;
                    end
                end
                ST_DROP: begin
                    if (accept && in_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed bench: an 8-channel router for routing/lock/backpressure behaviour
// and a 5-channel router for illegal-select dropping.
module tb_demux_stream_router;

    logic clk;
    logic rst_n;

    logic [7:0]  in_data8;
    logic        in_valid8;
    logic        in_last8;
    logic [2:0]  in_sel8;
    logic        in_ready8;
    logic [63:0] out_data8;
    logic [7:0]  out_valid8;
    logic [7:0]  out_last8;
    logic [7:0]  out_ready8;
    logic        err_sel8;
    logic        busy8;
    logic [2:0]  active_sel8;

    logic [7:0]  in_data5;
    logic        in_valid5;
    logic        in_last5;
    logic [2:0]  in_sel5;
    logic        in_ready5;
    logic [39:0] out_data5;
    logic [4:0]  out_valid5;
    logic [4:0]  out_last5;
    logic [4:0]  out_ready5;
    logic        err_sel5;
    logic        busy5;
    logic [2:0]  active_sel5;

    int check_count = 0;
    int pass_count  = 0;

    demux_stream_router #(.WIDTH(8), .N_OUT(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_last   (in_last8),
        .in_sel    (in_sel8),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_last  (out_last8),
        .out_ready (out_ready8),
        .err_sel   (err_sel8),
        .busy      (busy8),
        .active_sel(active_sel8)
    );

    demux_stream_router #(.WIDTH(8), .N_OUT(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_last   (in_last5),
        .in_sel    (in_sel5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_last  (out_last5),
        .out_ready (out_ready5),
        .err_sel   (err_sel5),
        .busy      (busy5),
        .active_sel(active_sel5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic [2:0] sel, input logic last);
        in_valid8 = valid;
        in_data8  = data;
        in_sel8   = sel;
        in_last8  = last;
        #1;
    endtask

    task automatic applyStimulus5(input logic valid, input logic [7:0] data,
                                  input logic [2:0] sel, input logic last);
        in_valid5 = valid;
        in_data5  = data;
        in_sel5   = sel;
        in_last5  = last;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid8  = 1'b1;
        in_data8   = 8'h55;
        in_sel8    = 3'd1;
        in_last8   = 1'b1;
        out_ready8 = 8'hFF;
        in_valid5  = 1'b1;
        in_data5   = 8'h55;
        in_sel5    = 3'd1;
        in_last5   = 1'b1;
        out_ready5 = 5'h1F;

        // Asynchronous reset asserted before any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid8), 64'h00);
        checkOutput("rst_busy", 64'(busy8), 64'h0);
        checkOutput("rst_err_sel", 64'(err_sel8), 64'h0);
        checkOutput("rst_active_sel", 64'(active_sel8), 64'h0);
        checkOutput("rst_out_data", out_data8, 64'h0);
        checkOutput("rst5_out_valid", 64'(out_valid5), 64'h00);

        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        applyStimulus5(1'b0, 8'h00, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();

        // Single-beat packets to every channel on consecutive cycles
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(k), 3'(k), 1'b1);
            checkOutput($sformatf("single_in_ready_%0d", k), 64'(in_ready8), 64'h1);
            stepCycle();
            checkOutput($sformatf("single_valid_%0d", k), 64'(out_valid8), 64'(8'h01 << k));
            checkOutput($sformatf("single_data_%0d", k), 64'(out_data8[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
            checkOutput($sformatf("single_last_%0d", k), 64'(out_last8[k]), 64'h1);
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        stepCycle();
        checkOutput("single_drained", 64'(out_valid8), 64'h00);

        // Packet lock: sel changes mid-packet must be ignored
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 8'h10 + 8'(j), (j == 0) ? 3'd3 : 3'd5, (j == 3));
            stepCycle();
            checkOutput($sformatf("lock_valid_%0d", j), 64'(out_valid8), 64'h08);
            checkOutput($sformatf("lock_data_%0d", j), 64'(out_data8[3*8 +: 8]), 64'(8'h10 + 8'(j)));
            checkOutput($sformatf("lock_busy_%0d", j), 64'(busy8), (j < 3) ? 64'h1 : 64'h0);
            checkOutput($sformatf("lock_active_%0d", j), 64'(active_sel8), (j < 3) ? 64'h3 : 64'h0);
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        stepCycle();

        // Backpressure on channel 2
        out_ready8 = 8'hFB;
        applyStimulus(1'b1, 8'h20, 3'd2, 1'b1);
        checkOutput("bp_ready_first", 64'(in_ready8), 64'h1);
        stepCycle();
        checkOutput("bp_valid_first", 64'(out_valid8), 64'h04);
        checkOutput("bp_data_first", 64'(out_data8[2*8 +: 8]), 64'h20);
        applyStimulus(1'b1, 8'h21, 3'd2, 1'b1);
        checkOutput("bp_ready_blocked", 64'(in_ready8), 64'h0);
        stepCycle();
        checkOutput("bp_held_valid", 64'(out_valid8), 64'h04);
        checkOutput("bp_held_data", 64'(out_data8[2*8 +: 8]), 64'h20);
        out_ready8 = 8'hFF;
        #1;
        checkOutput("bp_ready_release", 64'(in_ready8), 64'h1);
        stepCycle();
        out_ready8 = 8'hFB;
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        checkOutput("bp_reload_valid", 64'(out_valid8), 64'h04);
        checkOutput("bp_reload_data", 64'(out_data8[2*8 +: 8]), 64'h21);

        // Isolation: channel 2 stays stalled while channel 6 streams
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 8'h60 + 8'(j), 3'd6, (j == 2));
            checkOutput($sformatf("iso_ready_%0d", j), 64'(in_ready8), 64'h1);
            stepCycle();
            checkOutput($sformatf("iso_valid_%0d", j), 64'(out_valid8), 64'h44);
            checkOutput($sformatf("iso_data6_%0d", j), 64'(out_data8[6*8 +: 8]), 64'(8'h60 + 8'(j)));
            checkOutput($sformatf("iso_data2_%0d", j), 64'(out_data8[2*8 +: 8]), 64'h21);
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        stepCycle();
        checkOutput("iso_ch6_drained", 64'(out_valid8), 64'h04);
        out_ready8 = 8'hFF;
        stepCycle();
        checkOutput("iso_all_drained", 64'(out_valid8), 64'h00);

        // Illegal select on the 5-channel router: whole packet dropped
        for (int j = 0; j < 3; j++) begin
            applyStimulus5(1'b1, 8'h50 + 8'(j), 3'd6, (j == 2));
            checkOutput($sformatf("ill_ready_%0d", j), 64'(in_ready5), 64'h1);
            stepCycle();
            checkOutput($sformatf("ill_err_%0d", j), 64'(err_sel5), (j == 0) ? 64'h1 : 64'h0);
            checkOutput($sformatf("ill_valid_%0d", j), 64'(out_valid5), 64'h00);
            checkOutput($sformatf("ill_busy_%0d", j), 64'(busy5), 64'h0);
        end
        applyStimulus5(1'b1, 8'h70, 3'd4, 1'b1);
        checkOutput("ill_next_ready", 64'(in_ready5), 64'h1);
        stepCycle();
        applyStimulus5(1'b0, 8'h00, 3'd0, 1'b0);
        checkOutput("ill_next_valid", 64'(out_valid5), 64'h10);
        checkOutput("ill_next_data", 64'(out_data5[4*8 +: 8]), 64'h70);
        checkOutput("ill_next_err", 64'(err_sel5), 64'h0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
